cdc_wr_arb: RTL and testbench

CDC_WR_ARB -- requirements
Module: cdc_wr_arb

---
 rtl/cdc_fifo_pkg.sv | 13 +
 rtl/cdc_wr_arb_rr_pick.sv | 29 ++
 rtl/cdc_wr_arb.sv | 166 ++++++++++++++++
 tb/tb_cdc_wr_arb.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_fifo_pkg.sv
// Shared types for the write arbiter: FSM state encoding and beat-counter width.
package cdc_fifo_pkg;

   localparam int CNT_W = 4;

   typedef logic [CNT_W-1:0] beat_cnt_t;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/cdc_wr_arb_rr_pick.sv
// Round-robin picker: first requester at or after start, wrapping modulo N.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic [IW-1:0] winner,
   output logic          any_valid
);

   logic [IW-1:0] idx_s;

   // scan from the farthest offset down so the nearest requester wins last
   always_comb begin
      winner    = '0;
      idx_s     = '0;
      any_valid = |req;
      for (int i = N - 1; i >= 0; i--) begin
         idx_s = IW'((int'(start) + i) % N);
         if (req[idx_s]) begin
            winner = idx_s;
         end else begin
            winner = winner;
         end
      end
   end

endmodule

// File: rtl/cdc_wr_arb.sv
// Round-robin burst arbiter feeding one FIFO write port from NREQ requesters.
// Optional per-requester beat statistics under macro CDC_WR_ARB_STAT_EN.
module cdc_wr_arb
   import cdc_fifo_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int DWIDTH = 8,
   parameter int BURST  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_en,
   input  logic [NREQ*DWIDTH-1:0]   req_wdata,
   output logic [NREQ-1:0]          req_rdy,
   output logic                     fifo_w_en,
   output logic [DWIDTH-1:0]        fifo_wdata,
   input  logic                     fifo_wrdy,
   output logic [$clog2(NREQ)-1:0]  gnt_id,
   output logic                     busy
`ifdef CDC_WR_ARB_STAT_EN
   ,
   output logic [NREQ*16-1:0]       gnt_cnt
`endif
);

   localparam int        IDW       = $clog2(NREQ);
   localparam beat_cnt_t BURST_C   = CNT_W'(BURST);
   localparam logic [IDW-1:0] LAST_INIT = IDW'(NREQ - 1);

   arb_state_t     state_r, state_nx_s;
   beat_cnt_t      cnt_r, cnt_nx_s, cnt_inc_s;
   logic [IDW-1:0] gnt_id_r, gnt_nx_s, last_gnt_r, last_nx_s;
   logic [IDW-1:0] rr_start_s, win_s;
   logic           any_s, xfer_s, end_s;
   logic           fifo_w_en_s;
   logic [DWIDTH-1:0] fifo_wdata_s;
   logic [NREQ-1:0]   req_rdy_s;

   function automatic logic [IDW-1:0] nxt_idx(input logic [IDW-1:0] i);
      if (i == IDW'(NREQ - 1)) begin
         return '0;
      end else begin
         return i + IDW'(1);
      end
   endfunction

   // arbitration starts after the previous owner: last_gnt from IDLE, gnt_id when chaining
   assign rr_start_s = (state_r == GRANT) ? nxt_idx(gnt_id_r) : nxt_idx(last_gnt_r);

   rr_pick #(.N(NREQ), .IW(IDW)) u_rr_pick (
      .req       (req_en),
      .start     (rr_start_s),
      .winner    (win_s),
      .any_valid (any_s)
   );

   assign xfer_s    = (state_r == GRANT) && req_en[gnt_id_r] && fifo_wrdy;
   assign cnt_inc_s = cnt_r + 4'd1;
   assign end_s     = !req_en[gnt_id_r] || (xfer_s && (cnt_inc_s == BURST_C));

   // state, grant and beat-counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         cnt_r      <= '0;
         gnt_id_r   <= '0;
         last_gnt_r <= LAST_INIT;
      end else begin
         state_r    <= state_nx_s;
         cnt_r      <= cnt_nx_s;
         gnt_id_r   <= gnt_nx_s;
         last_gnt_r <= last_nx_s;
      end
   end

   // next-state logic: a finished burst chains straight into the next winner
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      gnt_nx_s   = gnt_id_r;
      last_nx_s  = last_gnt_r;
      case (state_r)
         IDLE: begin
            if (any_s) begin
               gnt_nx_s   = win_s;
               cnt_nx_s   = '0;
               state_nx_s = GRANT;
            end else begin
               state_nx_s = IDLE;
            end
         end
         GRANT: begin
            if (end_s) begin
               last_nx_s = gnt_id_r;
               cnt_nx_s  = '0;
               if (any_s) begin
                  gnt_nx_s   = win_s;
                  state_nx_s = GRANT;
               end else begin
                  state_nx_s = IDLE;
               end
            end else if (xfer_s) begin
               cnt_nx_s = cnt_inc_s;
            end else begin
               cnt_nx_s = cnt_r;
            end
         end
         default: begin
            state_nx_s = IDLE;
            cnt_nx_s   = '0;
         end
      endcase
   end

   // datapath steering; everything is forced low while rst is asserted
   always_comb begin
      fifo_w_en_s  = 1'b0;
      fifo_wdata_s = '0;
      req_rdy_s    = '0;
      if ((state_r == GRANT) && !rst) begin
         fifo_w_en_s = req_en[gnt_id_r];
         for (int k = 0; k < NREQ; k++) begin
            if (gnt_id_r == IDW'(k)) begin
               fifo_wdata_s = req_wdata[k*DWIDTH +: DWIDTH];
               req_rdy_s[k] = fifo_wrdy;
            end else begin
               req_rdy_s[k] = 1'b0;
            end
         end
      end else begin
         fifo_w_en_s = 1'b0;
      end
   end

   assign fifo_w_en  = fifo_w_en_s;
   assign fifo_wdata = fifo_wdata_s;
   assign req_rdy    = req_rdy_s;
   assign busy       = (state_r == GRANT) && !rst;
   assign gnt_id     = rst ? '0 : gnt_id_r;

`ifdef CDC_WR_ARB_STAT_EN
   logic [15:0] stat_r [NREQ];

   // per-requester accepted-beat counters, saturating
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NREQ; k++) begin
            stat_r[k] <= 16'd0;
         end
      end else begin
         for (int k = 0; k < NREQ; k++) begin
            if (xfer_s && (gnt_id_r == IDW'(k)) && (stat_r[k] != 16'hFFFF)) begin
               stat_r[k] <= stat_r[k] + 16'd1;
            end else begin
               stat_r[k] <= stat_r[k];
            end
         end
      end
   end

   for (genvar g = 0; g < NREQ; g++) begin : g_stat
      assign gnt_cnt[g*16 +: 16] = rst ? 16'd0 : stat_r[g];
   end
`endif

endmodule

// File: tb/tb_cdc_wr_arb.sv
// Randomized scoreboard bench for cdc_wr_arb against a behavioural arbitration model.
module tb_cdc_wr_arb;

   localparam int NREQ   = 4;
   localparam int DWIDTH = 8;
   localparam int BURST  = 4;
   localparam int IDW    = 2;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NREQ-1:0]        req_en;
   logic [NREQ*DWIDTH-1:0] req_wdata;
   logic [NREQ-1:0]        req_rdy;
   logic                   fifo_w_en;
   logic [DWIDTH-1:0]      fifo_wdata;
   logic                   fifo_wrdy;
   logic [IDW-1:0]         gnt_id;
   logic                   busy;
`ifdef CDC_WR_ARB_STAT_EN
   logic [NREQ*16-1:0]     gnt_cnt;
`endif

   always #5 clk = ~clk;

   cdc_wr_arb #(.NREQ(NREQ), .DWIDTH(DWIDTH), .BURST(BURST)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_en     (req_en),
      .req_wdata  (req_wdata),
      .req_rdy    (req_rdy),
      .fifo_w_en  (fifo_w_en),
      .fifo_wdata (fifo_wdata),
      .fifo_wrdy  (fifo_wrdy),
      .gnt_id     (gnt_id),
      .busy       (busy)
`ifdef CDC_WR_ARB_STAT_EN
      ,
      .gnt_cnt    (gnt_cnt)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;
   int exp_q[$];
   int obs_ids[$];

   // behavioural model: who owns the port, beats taken in this burst, last owner
   bit m_grant = 1'b0;
   int m_gnt   = 0;
   int m_cnt   = 0;
   int m_last  = NREQ - 1;
   int m_beats[NREQ];

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rr(input int from, input logic [NREQ-1:0] r);
      for (int i = 1; i <= NREQ; i++) begin
         if (r[(from + i) % NREQ]) return (from + i) % NREQ;
      end
      return 0;
   endfunction

   function automatic int count_id(input int id);
      int c = 0;
      foreach (obs_ids[i]) if (obs_ids[i] == id) c++;
      return c;
   endfunction

   task automatic cycle(input logic [NREQ-1:0] r, input logic w, input logic rs);
      bit busy_e, xfer;
      int gnt_e;
      @(posedge clk);
      #1;
      req_en    = r;
      fifo_wrdy = w;
      rst       = rs;
      req_wdata = (NREQ*DWIDTH)'($urandom);
      #1;
      busy_e = m_grant && !rs;
      gnt_e  = rs ? 0 : m_gnt;
      xfer   = busy_e && r[m_gnt] && w;
      check("busy", int'(busy), int'(busy_e));
      check("gnt_id", int'(gnt_id), gnt_e);
      check("fifo_w_en", int'(fifo_w_en), int'(busy_e && r[m_gnt]));
      check("req_rdy", int'(req_rdy), busy_e ? (int'(w) << m_gnt) : 0);
      if (!busy_e) check("fifo_wdata_idle", int'(fifo_wdata), 0);
`ifdef CDC_WR_ARB_STAT_EN
      for (int k = 0; k < NREQ; k++)
         check("gnt_cnt", int'(gnt_cnt[k*16 +: 16]), rs ? 0 : m_beats[k]);
`endif
      if (xfer) exp_q.push_back(int'(req_wdata[m_gnt*DWIDTH +: DWIDTH]));
      if (rs) begin
         m_grant = 1'b0; m_cnt = 0; m_gnt = 0; m_last = NREQ - 1;
         foreach (m_beats[i]) m_beats[i] = 0;
      end else if (!m_grant) begin
         if (r != '0) begin
            m_gnt = rr(m_last, r); m_cnt = 0; m_grant = 1'b1;
         end
      end else begin
         if (xfer) begin
            m_cnt++;
            if (m_beats[m_gnt] < 65535) m_beats[m_gnt]++;
         end
         if (!r[m_gnt] || m_cnt == BURST) begin
            m_last = m_gnt;
            if (r != '0) begin
               m_gnt = rr(m_gnt, r); m_cnt = 0;
            end else begin
               m_grant = 1'b0;
            end
         end
      end
   endtask

   task automatic settle();
      cycle('0, 1'b1, 1'b1);
   endtask

   // monitor: every accepted beat must match the oldest expected beat
   always @(negedge clk) begin
      int e;
      if (fifo_w_en === 1'b1 && fifo_wrdy === 1'b1) begin
         obs_ids.push_back(int'(gnt_id));
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL beat_unexpected: got data %0d expected no beat", fifo_wdata);
         end else begin
            e = exp_q.pop_front();
            check("beat_data", int'(fifo_wdata), e);
         end
      end
   end

   initial begin
      logic [NREQ-1:0] rq;
      rst = 1'b1; req_en = '1; req_wdata = '0; fifo_wrdy = 1'b1;
      foreach (m_beats[i]) m_beats[i] = 0;

      // reset held with everyone requesting
      repeat (3) cycle(4'b1111, 1'b1, 1'b1);
      check("rst_busy", int'(busy), 0);
      check("rst_wen", int'(fifo_w_en), 0);
      check("rst_rdy", int'(req_rdy), 0);
      check("rst_gnt", int'(gnt_id), 0);
      cycle(4'b1111, 1'b1, 1'b0);
      check("first_idle_busy", int'(busy), 0);
      cycle(4'b1111, 1'b1, 1'b0);
      check("first_grant_busy", int'(busy), 1);
      check("first_grant_id", int'(gnt_id), 0);
      repeat (6) cycle(4'b1111, 1'b1, 1'b0);

      // alternating bursts between requesters 0 and 1
      settle();
      obs_ids.delete();
      repeat (17) cycle(4'b0011, 1'b1, 1'b0);
      settle();
      check("alt_beats", obs_ids.size(), 16);
      if (obs_ids.size() >= 16)
         for (int i = 0; i < 16; i++) check("alt_owner", obs_ids[i], (i / 4) % 2);

      // early release by requester 2 after two beats
      obs_ids.delete();
      cycle(4'b0100, 1'b1, 1'b0);
      repeat (2) cycle(4'b1111, 1'b1, 1'b0);
      cycle(4'b1011, 1'b1, 1'b0);
      cycle(4'b1011, 1'b1, 1'b0);
      check("early_next_id", int'(gnt_id), 3);
      settle();
      check("early_req2_beats", count_id(2), 2);

      // backpressure at beat 2
      obs_ids.delete();
      repeat (3) cycle(4'b0001, 1'b1, 1'b0);
      repeat (5) begin
         cycle(4'b0001, 1'b0, 1'b0);
         check("stall_wen", int'(fifo_w_en), 1);
         check("stall_gnt", int'(gnt_id), 0);
      end
      repeat (2) cycle(4'b0001, 1'b1, 1'b0);
      cycle(4'b0000, 1'b1, 1'b0);
      settle();
      check("stall_beats", obs_ids.size(), 4);

      // single requester 3, back-to-back bursts
      obs_ids.delete();
      cycle(4'b1000, 1'b1, 1'b0);
      repeat (12) begin
         cycle(4'b1000, 1'b1, 1'b0);
         check("single_busy", int'(busy), 1);
         check("single_gnt", int'(gnt_id), 3);
      end
      settle();
      check("single_beats", count_id(3), 12);

      // random traffic with random backpressure and occasional reset
      rq = 4'b0101;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(3, 0) == 0) rq = NREQ'($urandom);
         cycle(rq, ($urandom_range(3, 0) != 0), ($urandom_range(149, 0) == 0));
      end

`ifdef CDC_WR_ARB_STAT_EN
      settle();
      repeat (51) cycle(4'b0010, 1'b1, 1'b0);
      cycle(4'b0000, 1'b1, 1'b0);
      check("stat_req1", int'(gnt_cnt[16 +: 16]), 50);
      check("stat_req0", int'(gnt_cnt[0 +: 16]), 0);
      check("stat_req2", int'(gnt_cnt[32 +: 16]), 0);
      check("stat_req3", int'(gnt_cnt[48 +: 16]), 0);
      repeat (3) cycle(4'b0010, 1'b1, 1'b0);
      cycle(4'b0010, 1'b1, 1'b1);
      cycle(4'b0010, 1'b1, 1'b0);
      check("stat_cleared", int'(gnt_cnt[16 +: 16]), 0);
      check("stat_busy_after_rst", int'(busy), 0);
`endif

      settle();
      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
